// File: rtl/board_pkg.sv
// Shared cell encoding, FSM state type and opening-layout function for board_store.
package board_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_ATK   = 2'd1;
    localparam logic [1:0] CELL_DEF   = 2'd2;
    localparam logic [1:0] CELL_KING  = 2'd3;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_MOVE = 2'd2
    } board_state_e;

    // Opening layout: full Hnefatafl setup for 11x11, a lone centred king otherwise.
    function automatic logic [1:0] start_cell(input int x, input int y, input int n);
        logic [1:0] c;
        c = CELL_EMPTY;
        if (n == 11) begin
            if ((x == 0 || x == 10) && y >= 3 && y <= 7) c = CELL_ATK;
            if ((y == 0 || y == 10) && x >= 3 && x <= 7) c = CELL_ATK;
            if ((x == 1 || x == 9) && y == 5) c = CELL_ATK;
            if ((y == 1 || y == 9) && x == 5) c = CELL_ATK;
            if (y == 5 && (x == 3 || x == 4 || x == 6 || x == 7)) c = CELL_DEF;
            if (x == 5 && (y == 3 || y == 4 || y == 6 || y == 7)) c = CELL_DEF;
            if ((x == 4 || x == 6) && (y == 4 || y == 6)) c = CELL_DEF;
            if (x == 5 && y == 5) c = CELL_KING;
        end else if (x == n / 2 && y == n / 2) begin
            c = CELL_KING;
        end
        return c;
    endfunction

endpackage

// File: rtl/board_move_check.sv
// Combinational move legality: in range, distinct squares, occupied source,
// empty destination, straight line. Path clearance is left to the rules engine.
module board_move_check
    import board_pkg::*;
#(
    parameter int BOARD_N = 11,
    parameter int COORD_W = 4,
    parameter int CELL_W  = 2
) (
    input  logic [COORD_W-1:0] sx,
    input  logic [COORD_W-1:0] sy,
    input  logic [COORD_W-1:0] dx,
    input  logic [COORD_W-1:0] dy,
    input  logic [CELL_W-1:0]  src_cell,
    input  logic [CELL_W-1:0]  dst_cell,
    output logic               legal
);

    localparam logic [COORD_W:0] LIMIT = (COORD_W+1)'(BOARD_N);

    logic in_rng;
    logic same_sq;
    logic straight;

    assign in_rng   = ({1'b0, sx} < LIMIT) && ({1'b0, sy} < LIMIT) &&
                      ({1'b0, dx} < LIMIT) && ({1'b0, dy} < LIMIT);
    assign same_sq  = (sx == dx) && (sy == dy);
    assign straight = (sx == dx) || (sy == dy);

    assign legal = in_rng && !same_sq && straight &&
                   (src_cell != CELL_W'(CELL_EMPTY)) &&
                   (dst_cell == CELL_W'(CELL_EMPTY));

endmodule

// File: rtl/board_store.sv
// board_store: BOARD_N x BOARD_N cell store with combinational read ports, a direct
// write port, opening-layout loader and atomic moves. Macro BOARD_MOVE_CHECK_EN enables legality checks.
module board_store
    import board_pkg::*;
#(
    parameter int BOARD_N  = 11,
    parameter int COORD_W  = 4,
    parameter int CELL_W   = 2,
    parameter int RD_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [RD_PORTS*COORD_W-1:0]  rd_x,
    input  logic [RD_PORTS*COORD_W-1:0]  rd_y,
    output logic [RD_PORTS*CELL_W-1:0]   rd_data,
    input  logic                         wr_en,
    input  logic [COORD_W-1:0]           wr_x,
    input  logic [COORD_W-1:0]           wr_y,
    input  logic [CELL_W-1:0]            wr_data,
    input  logic                         mv_valid,
    output logic                         mv_ready,
    input  logic [COORD_W-1:0]           mv_sx,
    input  logic [COORD_W-1:0]           mv_sy,
    input  logic [COORD_W-1:0]           mv_dx,
    input  logic [COORD_W-1:0]           mv_dy,
    output logic                         mv_done,
    output logic                         mv_err,
    input  logic                         init_req,
    output logic                         busy,
    output board_state_e                 dbg_state
);

    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

    function automatic logic in_range(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return ({1'b0, x} < (COORD_W+1)'(BOARD_N)) && ({1'b0, y} < (COORD_W+1)'(BOARD_N));
    endfunction

    function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return IDX_W'(y) * IDX_W'(BOARD_N) + IDX_W'(x);
    endfunction

    board_state_e          state_q, state_d;
    logic [IDX_W-1:0]      i_q, i_d;
    logic [CELL_W-1:0]     cells_q [CELLS];
    logic [CELL_W-1:0]     cells_d [CELLS];
    logic [COORD_W-1:0]    sx_q, sx_d, sy_q, sy_d, dx_q, dx_d, dy_q, dy_d;
    logic                  mv_done_q, mv_done_d;
    logic                  mv_err_q, mv_err_d;

    logic                  src_ok, dst_ok, move_legal;
    logic [IDX_W-1:0]      src_idx, dst_idx, wr_idx;
    logic [CELL_W-1:0]     src_cell, dst_cell;

    assign src_ok   = in_range(sx_q, sy_q);
    assign dst_ok   = in_range(dx_q, dy_q);
    assign src_idx  = cell_idx(sx_q, sy_q);
    assign dst_idx  = cell_idx(dx_q, dy_q);
    assign wr_idx   = cell_idx(wr_x, wr_y);
    assign src_cell = src_ok ? cells_q[src_idx] : '0;
    assign dst_cell = dst_ok ? cells_q[dst_idx] : '0;

`ifdef BOARD_MOVE_CHECK_EN
    board_move_check #(
        .BOARD_N (BOARD_N),
        .COORD_W (COORD_W),
        .CELL_W  (CELL_W)
    ) u_move_check (
        .sx       (sx_q),
        .sy       (sy_q),
        .dx       (dx_q),
        .dy       (dy_q),
        .src_cell (src_cell),
        .dst_cell (dst_cell),
        .legal    (move_legal)
    );
`else
    assign move_legal = src_ok && dst_ok;
`endif

    // Out-of-range read coordinates return empty instead of aliasing another cell.
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            if (in_range(rd_x[p*COORD_W +: COORD_W], rd_y[p*COORD_W +: COORD_W])) begin
                rd_data[p*CELL_W +: CELL_W] =
                    cells_q[cell_idx(rd_x[p*COORD_W +: COORD_W], rd_y[p*COORD_W +: COORD_W])];
            end
        end
    end

    // Move handshake: a request transfers on a rising edge where mv_valid && mv_ready.
    // mv_ready is high only in IDLE with no competing write or reload that cycle;
    // mv_valid may be held across cycles and is consumed exactly once per transfer.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        cells_d   = cells_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        mv_done_d = 1'b0;
        mv_err_d  = 1'b0;
        mv_ready  = 1'b0;
        case (state_q)
            ST_INIT: begin
                for (int c = 0; c < CELLS; c++) begin
                    if (IDX_W'(c) == i_q) begin
                        cells_d[c] = CELL_W'(start_cell(c % BOARD_N, c / BOARD_N, BOARD_N));
                    end
                end
                i_d = i_q + IDX_W'(1);
                if (i_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    i_d     = '0;
                end
            end
            ST_IDLE: begin
                mv_ready = !wr_en && !init_req;
                if (init_req) begin
                    state_d = ST_INIT;
                    i_d     = '0;
                end else if (wr_en) begin
                    for (int c = 0; c < CELLS; c++) begin
                        if (in_range(wr_x, wr_y) && IDX_W'(c) == wr_idx) cells_d[c] = wr_data;
                    end
                end else if (mv_valid) begin
                    sx_d    = mv_sx;
                    sy_d    = mv_sy;
                    dx_d    = mv_dx;
                    dy_d    = mv_dy;
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                // Clear source before writing destination so a self-move leaves the cell intact.
                if (move_legal) begin
                    for (int c = 0; c < CELLS; c++) begin
                        if (IDX_W'(c) == src_idx) cells_d[c] = '0;
                    end
                    for (int c = 0; c < CELLS; c++) begin
                        if (IDX_W'(c) == dst_idx) cells_d[c] = src_cell;
                    end
                end
                mv_done_d = 1'b1;
`ifdef BOARD_MOVE_CHECK_EN
                mv_err_d  = !move_legal;
`endif
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
                i_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            i_q       <= '0;
            for (int c = 0; c < CELLS; c++) cells_q[c] <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            mv_done_q <= 1'b0;
            mv_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            cells_q   <= cells_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            mv_done_q <= mv_done_d;
            mv_err_q  <= mv_err_d;
        end
    end

    assign mv_done   = mv_done_q;
    assign mv_err    = mv_err_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule
